// File: rtl/sharpen_pkg.sv
// Shared types and constants for the sharpening datapath (adder stage and serializer).
// Holds pixel/accumulator widths, the 3x3 window type and the serializer state encoding.
// No logic of its own; win_elem is a pure helper used to select a window element by raster index.
package sharpen_pkg;

    localparam int PIX_W   = 8;
    localparam int ACC_W   = 12;
    localparam int PIX_MAX = 255;
    localparam int WIN_LEN = 9;

    typedef logic [PIX_W-1:0]        pix_t;
    typedef logic signed [ACC_W-1:0] acc_t;
    typedef acc_t [0:2][0:2]         win_acc_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ser_state_t;

    localparam logic [3:0] LAST_IDX = 4'(WIN_LEN - 1);

    // Select element idx = row*3 + col; out-of-range indices return zero.
    function automatic acc_t win_elem(input win_acc_t w, input logic [3:0] i);
        acc_t e;
        e = '0;
        for (int k = 0; k < WIN_LEN; k++) begin
            if (i == 4'(k)) begin
                e = w[k / 3][k % 3];
            end
        end
        return e;
    endfunction

endpackage

// File: rtl/pixel_clamp.sv
// Purpose: clamp one signed accumulator value into the unsigned 8-bit pixel range.
// Latency: combinational, zero cycles.
// Backpressure: none (pure function). Ports: acc in, pix out, clamped = value was altered.
module pixel_clamp
    import sharpen_pkg::*;
(
    input  acc_t        acc,
    output pix_t        pix,
    output logic        clamped
);

    always_comb begin
        pix     = acc[PIX_W-1:0];
        clamped = 1'b0;
        if (acc[ACC_W-1]) begin
            pix     = '0;
            clamped = 1'b1;
        end else if (acc > acc_t'(PIX_MAX)) begin
            pix     = pix_t'(PIX_MAX);
            clamped = 1'b1;
        end
    end

endmodule

// File: rtl/sharpen_window_serializer.sv
// Purpose: capture a 3x3 window of signed results, clamp each and stream 9 pixels in raster order.
// Latency: first pixel valid the cycle after window accept; 9 cycles/window at full rate, no bubble.
// Backpressure: pix_ready low holds pix_out/flags/idx; win_ready only at idle or on the last-pixel transfer.
// Ports: win_in/win_valid/win_ready (window in), pix_out/pix_valid/pix_ready + first/row_last/last flags
// (pixel out), sat_cnt = count of transferred pixels that needed clamping (saturating).
module sharpen_window_serializer
    import sharpen_pkg::*;
#(
    parameter int IN_W  = 12,
    parameter int OUT_W = 8,
    parameter int CNT_W = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [0:2][0:2][IN_W-1:0]     win_in,
    input  logic                          win_valid,
    output logic                          win_ready,
    output logic [OUT_W-1:0]              pix_out,
    output logic                          pix_valid,
    input  logic                          pix_ready,
    output logic                          pix_first,
    output logic                          pix_row_last,
    output logic                          pix_last,
    output logic [CNT_W-1:0]              sat_cnt
);

    ser_state_t state, state_nxt;
    logic [3:0] idx, idx_nxt;
    win_acc_t   cap;
    logic       load;
    logic       pix_xfer;
    acc_t       cur_elem;
    pix_t       cur_pix;
    logic       cur_clamped;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        win_ready = 1'b0;
        pix_valid = 1'b0;
        load      = 1'b0;
        case (state)
            ST_IDLE: begin
                win_ready = 1'b1;
                if (win_valid) begin
                    state_nxt = ST_SEND;
                    idx_nxt   = '0;
                    load      = 1'b1;
                end
            end
            ST_SEND: begin
                pix_valid = 1'b1;
                // Opening the window port on the final transfer gives back-to-back windows.
                win_ready = (idx == LAST_IDX) && pix_ready;
                if (pix_ready) begin
                    if (idx == LAST_IDX) begin
                        idx_nxt = '0;
                        if (win_valid) begin
                            load = 1'b1;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        idx_nxt = idx + 4'd1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    // Capture register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap <= '0;
        end else if (load) begin
            cap <= win_in;
        end
    end

    // One clamp after the element mux keeps the output path to a single comparator pair.
    assign cur_elem = win_elem(cap, idx);

    pixel_clamp u_clamp (
        .acc     (cur_elem),
        .pix     (cur_pix),
        .clamped (cur_clamped)
    );

    assign pix_out      = cur_pix;
    assign pix_first    = (idx == 4'd0);
    assign pix_row_last = (idx == 4'd2) || (idx == 4'd5) || (idx == LAST_IDX);
    assign pix_last     = (idx == LAST_IDX);
    assign pix_xfer     = pix_valid && pix_ready;

    // Saturation-event counter, holds at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= '0;
        end else if (pix_xfer && cur_clamped && (sat_cnt != '1)) begin
            sat_cnt <= sat_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sharpen_window_serializer.sv
module tb_sharpen_window_serializer;
    import sharpen_pkg::*;

    typedef int vals_t [9];

    logic                       clk;
    logic                       rst_n;
    logic [0:2][0:2][11:0]      win_in;
    logic                       win_valid;
    logic                       win_ready;
    logic [7:0]                 pix_out;
    logic                       pix_valid;
    logic                       pix_ready;
    logic                       pix_first;
    logic                       pix_row_last;
    logic                       pix_last;
    logic [15:0]                sat_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_sat = 0;

    sharpen_window_serializer #(.IN_W(12), .OUT_W(8), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .win_in       (win_in),
        .win_valid    (win_valid),
        .win_ready    (win_ready),
        .pix_out      (pix_out),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_first    (pix_first),
        .pix_row_last (pix_row_last),
        .pix_last     (pix_last),
        .sat_cnt      (sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
            $error("%s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference clamp: saturate to [0,255]
    function automatic int clamp_ref(input int v);
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction

    function automatic win_acc_t mk(input vals_t v);
        win_acc_t w;
        for (int i = 0; i < 9; i++) w[i / 3][i % 3] = acc_t'(v[i]);
        return w;
    endfunction

    function automatic vals_t rand_vals();
        vals_t v;
        for (int i = 0; i < 9; i++) begin
            case ($urandom_range(3))
                0: v[i] = int'($urandom_range(4095)) - 2048;
                1: v[i] = int'($urandom_range(255));
                2: v[i] = int'($urandom_range(4)) + 253;
                default: v[i] = int'($urandom_range(3)) - 2;
            endcase
        end
        return v;
    endfunction

    // Offer a window from idle; it must be accepted on the next edge.
    task automatic load_window(input vals_t v);
        @(negedge clk);
        win_in    = mk(v);
        win_valid = 1'b1;
        #1;
        chk("win_ready_idle", win_ready, 1);
        @(posedge clk);
    endtask

    // Stream npix pixels of window v; optionally offer window nv throughout.
    task automatic drain(input vals_t v, input int pct, input bit offer, input vals_t nv, input int npix);
        int k;
        int cyc;
        k = 0;
        cyc = 0;
        while (k < npix && cyc < 400) begin
            @(negedge clk);
            pix_ready = ($urandom_range(99) < pct);
            win_valid = offer;
            win_in    = offer ? mk(nv) : '0;
            #1;
            chk("pix_valid", pix_valid, 1);
            chk("pix_out", pix_out, clamp_ref(v[k]));
            chk("flags", {pix_first, pix_row_last, pix_last}, {k == 0, (k % 3) == 2, k == 8});
            chk("win_ready", win_ready, (k == 8) && pix_ready);
            @(posedge clk);
            if (pix_ready) begin
                if (v[k] < 0 || v[k] > 255) exp_sat++;
                k++;
            end
            cyc++;
        end
        if (k < npix) chk("timeout", k, npix);
        #1;
        chk("sat_cnt", sat_cnt, exp_sat);
    endtask

    initial begin
        vals_t v1, v2, vz;
        vals_t r[5];
        for (int i = 0; i < 9; i++) vz[i] = 0;

        rst_n     = 1'b0;
        pix_ready = 1'b0;
        win_valid = 1'b0;
        win_in    = '0;
        #1;
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_win_ready", win_ready, 1);
        chk("rst_sat", sat_cnt, 0);
        chk("rst_pix_out", pix_out, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("idle_pix_valid", pix_valid, 0);
        chk("idle_win_ready", win_ready, 1);
        chk("idle_sat", sat_cnt, 0);
        chk("idle_pix_out", pix_out, 0);

        // Single window at full rate
        v1 = '{0, 255, 0, -1, 5, -1, 0, -1, 0};
        load_window(v1);
        drain(v1, 100, 1'b0, vz, 9);
        chk("sat_w1", sat_cnt, 3);
        @(negedge clk);
        #1;
        chk("idle_after_w1", pix_valid, 0);

        // Clamp boundaries
        v2 = '{-2048, -1, 0, 255, 256, 2047, 1, 128, 254};
        load_window(v2);
        drain(v2, 100, 1'b0, vz, 9);
        chk("sat_w2", sat_cnt, 7);

        // Back-to-back: 18 pixels with no gap
        load_window(v1);
        drain(v1, 100, 1'b1, v2, 9);
        drain(v2, 100, 1'b0, vz, 9);

        // Backpressure with next window offered mid-stream, random data
        for (int i = 0; i < 5; i++) r[i] = rand_vals();
        load_window(r[0]);
        for (int i = 0; i < 4; i++) drain(r[i], 55, 1'b1, r[i + 1], 9);
        drain(r[4], 55, 1'b0, vz, 9);

        // Reset mid-stream after 4 pixels
        r[0] = rand_vals();
        load_window(r[0]);
        drain(r[0], 100, 1'b0, vz, 4);
        @(negedge clk);
        pix_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        exp_sat = 0;
        chk("midrst_pix_valid", pix_valid, 0);
        chk("midrst_sat", sat_cnt, 0);
        chk("midrst_win_ready", win_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("postrst_pix_valid", pix_valid, 0);
        r[1] = rand_vals();
        load_window(r[1]);
        drain(r[1], 70, 1'b0, vz, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sharpen_window_serializer.md
# sharpen_window_serializer

Consumer end of the sharpening adder's output interface. Accepts one 3x3 window of signed 12-bit sharpened results per handshake, clamps each element to the unsigned 8-bit pixel range, and streams the nine pixels out in raster order over a valid/ready pixel interface. It sits between the addition stage and the frame writer, and converts parallel window results back into a pixel stream.

## Interface
- IN_W, 12, signed width of each incoming window element
- OUT_W, 8, unsigned output pixel width
- CNT_W, 16, width of the saturation-event counter
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; asynchronous, active-low
- win_in  input  3x3 x IN_W signed  window, indexed [row 0:2][col 0:2]
- win_valid  input  1  win_in is valid
- win_ready  output  1  block can accept a window this cycle
- pix_out  output  OUT_W  clamped pixel
- pix_valid  output  1  pix_out is valid
- pix_ready  input  1  downstream accepts pix_out
- pix_first  output  1  pix_out is element [0][0]
- pix_row_last  output  1  pix_out is column 2 of its row
- pix_last  output  1  pix_out is element [2][2]
- sat_cnt  output  CNT_W  number of transferred pixels that were clamped; saturates at all-ones

## Operation
- The FSM has two states, IDLE and SEND. It holds one captured window register (9 x IN_W) and a 4-bit index idx from 0 to 8. Element order is idx = row*3 + col.
- Window accept: a window transfers when win_valid && win_ready. The block registers win_in into the capture register, sets idx to 0 and enters SEND.
- win_ready = (state==IDLE) || (state==SEND && idx==8 && pix_ready). This allows back-to-back windows with no bubble.
- In SEND:
  - pix_valid = 1.
  - pix_out = clamp(captured[idx]).
  - A pixel transfers on pix_valid && pix_ready. On transfer with idx<8, idx increments.
  - On transfer with idx==8, the block returns to IDLE, or stays in SEND with idx=0 and the new window if one is accepted in the same cycle.
- Clamp rule:
  - value < 0 gives 0.
  - value > 255 gives 255.
  - Otherwise the output is the low 8 bits of the value.
  - Boundaries: -1 gives 0, 0 gives 0, 255 gives 255, 256 gives 255, -2048 gives 0, 2047 gives 255.
- sat_cnt increments by 1 on each transferred pixel whose value was clamped, including in-range-boundary cases only when the value was actually altered (so 0 and 255 do not count). It holds at 2^CNT_W-1.
- Flags are valid only with pix_valid:
  - pix_first = (idx==0).
  - pix_row_last = (idx==2 || idx==5 || idx==8).
  - pix_last = (idx==8).
- Stall: while pix_valid && !pix_ready, pix_out, the flags and idx hold stable. win_in is ignored because win_ready = 0.
- win_valid asserted while in SEND with idx<8 is not accepted. The upstream holds the window.

## Timing
- Reset values:
  - state = IDLE, idx = 0, capture register = 0, sat_cnt = 0.
  - Outputs: pix_valid=0, pix_out=0, pix_first=1, pix_row_last=0, pix_last=0, win_ready=1 (the flags are don't-care while pix_valid=0).
- Latency: the first pixel is valid on the cycle after the window-accept edge.
- Throughput: 9 cycles per window with pix_ready held high. Continuous windows give continuous pix_valid.
- pix_out, pix_valid and the flags come combinationally from registered state and the capture register. There is no path from any input to pix_out or pix_valid.
- win_ready has a combinational path from pix_ready only. Upstream must not make win_valid depend on win_ready.
- Reset asserted mid-window discards the window. Outputs reach reset values asynchronously and no partial pixels are emitted after release.

## Structure
- Shared package sharpen_pkg:
  - PIX_W=8 and ACC_W=12.
  - typedef pix_t (logic [7:0]).
  - typedef acc_t (logic signed [11:0]).
  - typedef win_acc_t (acc_t [0:2][0:2]).
  - Constants PIX_MAX=255 and WIN_LEN=9.
  - The addition stage uses the same types.
- Sub-module pixel_clamp: combinational. Takes acc_t in and produces pix_t out plus a clamped flag. It is instantiated once after the idx mux.

## Test plan
- Reset and idle: hold rst_n=0, then release with no window. Check pix_valid=0, win_ready=1, sat_cnt=0 and pix_out=0.
- Single window with pix_ready=1: window {{0,255,0},{-1,5,-1},{0,-1,0}}.
  - Output, in order from the cycle after accept: 0,255,0,0,5,0,0,0,0.
  - pix_first on the 1st pixel, pix_row_last on the 3rd/6th/9th, pix_last on the 9th.
  - sat_cnt ends at 3.
- Clamp boundaries: window {{-2048,-1,0},{255,256,2047},{1,128,254}}.
  - Output: 0,0,0,255,255,255,1,128,254.
  - sat_cnt increases by 4.
- Back-to-back: two windows, win_valid held high, pix_ready=1. Check 18 consecutive valid pixels with no gap, and win_ready high only in the idx==8 cycle.
- Backpressure: toggle pix_ready pseudo-randomly. Check pix_out and the flags stay stable while stalled, all 9 pixels arrive in order with none lost or duplicated, and a window offered mid-stream is not accepted until idx==8 transfers.
- Reset mid-stream: assert rst_n low after pixel 4 is transferred. Check pix_valid drops immediately, sat_cnt=0, and after release the next window streams from [0][0].
